// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: step modes and multi-step FSM states.
package usr_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_HOLD2 = 3'b111
    } mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Modes that may be repeated by the multi-step engine.
    function automatic logic is_multi(input mode_t m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
               (m == MODE_ROTR) || (m == MODE_ASR);
    endfunction

    // Modes whose outgoing bit is the MSB (the rest that shift use the LSB).
    function automatic logic out_from_msb(input mode_t m);
        return (m == MODE_SHL) || (m == MODE_ROTL);
    endfunction

    function automatic logic out_from_lsb(input mode_t m);
        return (m == MODE_SHR) || (m == MODE_ROTR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/universal_shift_register_shift_step.sv
// One-step next-value function shared by the single-step and multi-step paths.
module shift_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in};
            MODE_SHR:  q_next = {ser_in, q[WIDTH-1:1]};
            MODE_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR: q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised register with parallel load, single-step shift/rotate and a
// multi-cycle shift-by-N engine with busy/done handshake.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int unsigned      CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nx;
    mode_t            lmode, lmode_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] q_nx, step_q;
    logic             busy_nx, done_nx;
    mode_t            mode_live, step_mode, out_mode;

    assign mode_live = mode_t'(mode);
    assign step_mode = (state == ST_SHIFT) ? lmode : mode_live;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q      (q),
        .mode   (step_mode),
        .ser_in (ser_in),
        .d      (d),
        .q_next (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            lmode <= MODE_HOLD;
            cnt   <= '0;
            q     <= RST_VAL;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            lmode <= lmode_nx;
            cnt   <= cnt_nx;
            q     <= q_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    // Priority: clr, then an active multi-step op, then start accept, then single step.
    always_comb begin
        state_nx = state;
        lmode_nx = lmode;
        cnt_nx   = cnt;
        q_nx     = q;
        busy_nx  = busy;
        done_nx  = 1'b0;
        if (clr) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            q_nx     = RST_VAL;
            busy_nx  = 1'b0;
        end else if (state == ST_SHIFT) begin
            if (en) begin
                q_nx   = step_q;
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = ST_IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
        end else if (start && is_multi(mode_live)) begin
            lmode_nx = mode_live;
            cnt_nx   = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;
            if (cnt_nx == '0) begin
                done_nx = 1'b1;
            end else begin
                state_nx = ST_SHIFT;
                busy_nx  = 1'b1;
            end
        end else if (en) begin
            q_nx = step_q;
        end
    end

    // Outgoing bit follows the mode that the next step will actually use.
    assign out_mode = busy ? lmode : mode_live;

    always_comb begin
        ser_out = 1'b0;
        if (out_from_msb(out_mode)) begin
            ser_out = q[WIDTH-1];
        end else if (out_from_lsb(out_mode)) begin
            ser_out = q[0];
        end
    end

endmodule
